// File: rtl/simd_sequencer_if.sv
// Handshake and control bundle between a SIMD sequencer and the fetch, decode,
// LSU and lane datapath blocks it steers.
interface simd_sequencer_if #(
    parameter int WAVE_SIZE  = 32,
    parameter int LANE_WIDTH = 16,
    parameter int PC_WIDTH   = 8
);
    localparam int CYCLES = WAVE_SIZE / LANE_WIDTH;
    localparam int CW     = (CYCLES > 2) ? $clog2(CYCLES) : 1;

    logic                  start;
    logic [31:0]           block_dim;
    logic                  fetch_req;
    logic                  fetch_valid;
    logic [31:0]           instr_in;
    logic [31:0]           instr;
    logic                  is_mem;
    logic                  is_ret;
    logic                  branch_taken;
    logic [PC_WIDTH-1:0]   branch_target;
    logic                  mem_ready;
    logic [2:0]            simd_state;
    logic [31:0]           wave_id;
    logic [CW-1:0]         curr_wave_cycle;
    logic [LANE_WIDTH-1:0] lane_mask;
    logic [PC_WIDTH-1:0]   pc;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, block_dim, fetch_valid, instr_in, is_mem, is_ret,
               branch_taken, branch_target, mem_ready,
        output fetch_req, instr, simd_state, wave_id, curr_wave_cycle,
               lane_mask, pc, busy, done
    );

    modport slave (
        output start, block_dim, fetch_valid, instr_in, is_mem, is_ret,
               branch_taken, branch_target, mem_ready,
        input  fetch_req, instr, simd_state, wave_id, curr_wave_cycle,
               lane_mask, pc, busy, done
    );
endinterface

// File: rtl/simd_sequencer.sv
// Per-SIMD-unit sequencer: walks a thread block wave by wave, instruction by
// instruction, and lane group by lane group within each wave.
module simd_sequencer #(
    parameter int WAVE_SIZE  = 32,
    parameter int LANE_WIDTH = 16,
    parameter int PC_WIDTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    simd_sequencer_if.master   bus
);
    localparam int CYCLES = WAVE_SIZE / LANE_WIDTH;
    localparam int CW     = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CYC = CW'(CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_REQUEST = 3'd3,
        S_WAIT    = 3'd4,
        S_EXECUTE = 3'd5,
        S_UPDATE  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         bd_q, bd_d;
    logic [32:0]         nwaves_q, nwaves_d;
    logic [31:0]         wave_q, wave_d;
    logic [CW-1:0]       cyc_q, cyc_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic                mem_q, mem_d;
    logic                ret_q, ret_d;

    // 33-bit sum so block_dim near 2^32 cannot wrap before the divide
    logic [32:0] nw_calc;
    assign nw_calc = (33'(bus.block_dim) + 33'(WAVE_SIZE - 1)) / 33'(WAVE_SIZE);

    logic last_wave;
    assign last_wave = ({1'b0, wave_q} == (nwaves_q - 33'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            bd_q     <= '0;
            nwaves_q <= '0;
            wave_q   <= '0;
            cyc_q    <= '0;
            pc_q     <= '0;
            instr_q  <= '0;
            mem_q    <= 1'b0;
            ret_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bd_q     <= bd_d;
            nwaves_q <= nwaves_d;
            wave_q   <= wave_d;
            cyc_q    <= cyc_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            mem_q    <= mem_d;
            ret_q    <= ret_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bd_d     = bd_q;
        nwaves_d = nwaves_q;
        wave_d   = wave_q;
        cyc_d    = cyc_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        mem_d    = mem_q;
        ret_d    = ret_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    bd_d     = bus.block_dim;
                    nwaves_d = nw_calc;
                    if (nw_calc == 33'd0) begin
                        state_d = S_DONE;
                    end else begin
                        wave_d  = '0;
                        pc_d    = '0;
                        cyc_d   = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (bus.fetch_valid) begin
                    instr_d = bus.instr_in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                mem_d   = bus.is_mem;
                ret_d   = bus.is_ret;
                state_d = S_REQUEST;
            end
            S_REQUEST: state_d = mem_q ? S_WAIT : S_EXECUTE;
            S_WAIT: begin
                if (bus.mem_ready) state_d = S_EXECUTE;
            end
            S_EXECUTE: state_d = S_UPDATE;
            S_UPDATE: begin
                // Remaining lane groups reuse the latched instruction
                if (cyc_q != LAST_CYC) begin
                    cyc_d   = cyc_q + CW'(1);
                    state_d = S_REQUEST;
                end else begin
                    cyc_d = '0;
                    if (ret_q) begin
                        if (last_wave) begin
                            state_d = S_DONE;
                        end else begin
                            wave_d  = wave_q + 32'd1;
                            pc_d    = '0;
                            state_d = S_FETCH;
                        end
                    end else begin
                        pc_d    = bus.branch_taken ? bus.branch_target : pc_q + PC_WIDTH'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // 64-bit thread index keeps the last wave of a near-2^32 block exact
    logic [63:0]           base;
    logic [LANE_WIDTH-1:0] mask;
    always_comb begin
        base = 64'(wave_q) * 64'(WAVE_SIZE) + 64'(cyc_q) * 64'(LANE_WIDTH);
        mask = '0;
        for (int l = 0; l < LANE_WIDTH; l++) begin
            mask[l] = (base + 64'(l)) < 64'(bd_q);
        end
    end

    assign bus.lane_mask       = mask;
    assign bus.simd_state      = state_q;
    assign bus.wave_id         = wave_q;
    assign bus.curr_wave_cycle = cyc_q;
    assign bus.pc              = pc_q;
    assign bus.instr           = instr_q;
    assign bus.fetch_req       = (state_q == S_FETCH);
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.done            = (state_q == S_DONE);
endmodule

// File: tb/tb_simd_sequencer.sv
// Bench for simd_sequencer: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a program-level reference model.
module tb_simd_sequencer;
    localparam int WAVE_SIZE  = 32;
    localparam int LANE_WIDTH = 16;
    localparam int PC_WIDTH   = 8;
    localparam int CYCLES     = WAVE_SIZE / LANE_WIDTH;
    localparam int CW         = (CYCLES > 2) ? $clog2(CYCLES) : 1;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_REQUEST = 3;
    localparam int ST_WAIT = 4, ST_EXECUTE = 5, ST_UPDATE = 6, ST_DONE = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    simd_sequencer_if #(.WAVE_SIZE(WAVE_SIZE), .LANE_WIDTH(LANE_WIDTH), .PC_WIDTH(PC_WIDTH)) ifc();
    simd_sequencer #(.WAVE_SIZE(WAVE_SIZE), .LANE_WIDTH(LANE_WIDTH), .PC_WIDTH(PC_WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    // Program memory and a trivial decoder: bit0 = memory op, bit1 = return
    logic [31:0] prog [256];
    assign ifc.instr_in = prog[ifc.pc];
    assign ifc.is_mem   = ifc.instr[0];
    assign ifc.is_ret   = ifc.instr[1];

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: runs the program per wave and expands each fetched
    // instruction into the list of phases it must pass through.
    int                  m_state = ST_IDLE;
    longint              m_wave = 0, m_nw = 0, m_bd = 0;
    int                  m_cycle = 0;
    logic [PC_WIDTH-1:0] m_pc = '0;
    logic [31:0]         m_instr = '0;
    int                  q_st[$];
    int                  q_cyc[$];

    task automatic next_phase();
        if (q_st.size() > 0) begin
            m_state = q_st.pop_front();
            m_cycle = q_cyc.pop_front();
        end else begin
            m_cycle = 0;
            if (m_instr[1]) begin
                if (m_wave == m_nw - 1) m_state = ST_DONE;
                else begin
                    m_wave  = m_wave + 1;
                    m_pc    = '0;
                    m_state = ST_FETCH;
                end
            end else begin
                m_pc    = ifc.branch_taken ? ifc.branch_target : m_pc + 8'd1;
                m_state = ST_FETCH;
            end
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_state = ST_IDLE; m_wave = 0; m_cycle = 0; m_pc = '0; m_instr = '0; m_bd = 0;
            q_st.delete(); q_cyc.delete();
            return;
        end
        case (m_state)
            ST_IDLE: if (ifc.start) begin
                m_bd = longint'(ifc.block_dim);
                m_nw = (m_bd + WAVE_SIZE - 1) / WAVE_SIZE;
                if (m_nw == 0) m_state = ST_DONE;
                else begin
                    m_wave = 0; m_pc = '0; m_cycle = 0; m_state = ST_FETCH;
                end
            end
            ST_DONE: m_state = ST_IDLE;
            ST_FETCH: if (ifc.fetch_valid) begin
                m_instr = prog[m_pc];
                q_st.push_back(ST_DECODE); q_cyc.push_back(0);
                for (int c = 0; c < CYCLES; c++) begin
                    q_st.push_back(ST_REQUEST); q_cyc.push_back(c);
                    if (m_instr[0]) begin q_st.push_back(ST_WAIT); q_cyc.push_back(c); end
                    q_st.push_back(ST_EXECUTE); q_cyc.push_back(c);
                    q_st.push_back(ST_UPDATE);  q_cyc.push_back(c);
                end
                next_phase();
            end
            ST_WAIT: if (ifc.mem_ready) next_phase();
            default: next_phase();
        endcase
    endtask

    function automatic logic [LANE_WIDTH-1:0] exp_mask();
        longint rem;
        rem = m_bd - m_wave * WAVE_SIZE - longint'(m_cycle) * LANE_WIDTH;
        if (rem <= 0) return '0;
        if (rem >= LANE_WIDTH) return '1;
        return LANE_WIDTH'((64'd1 << rem) - 64'd1);
    endfunction

    task automatic compare();
        chk("state_flags", 64'({ifc.simd_state, ifc.fetch_req, ifc.busy, ifc.done}),
            64'({3'(m_state), m_state == ST_FETCH, m_state != ST_IDLE, m_state == ST_DONE}));
        chk("wave_id", 64'(ifc.wave_id), 64'(32'(m_wave)));
        chk("cycle_pc", 64'({ifc.curr_wave_cycle, ifc.pc}), 64'({CW'(m_cycle), m_pc}));
        chk("instr", 64'(ifc.instr), 64'(m_instr));
        chk("lane_mask", 64'(ifc.lane_mask), 64'(exp_mask()));
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) compare();
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Directed-scenario helpers
    int                    cap_st   [64];
    logic [31:0]           cap_wave [64];
    logic [PC_WIDTH-1:0]   cap_pc   [64];
    logic [LANE_WIDTH-1:0] cap_mask [64];
    logic                  cap_done [64];

    int exp_basic [18] = '{1,2,3,5,6,3,5,6,1,2,3,5,6,3,5,6,7,0};
    int exp_mem   [16] = '{1,2,3,4,4,4,5,6,3,4,4,4,5,6,7,0};

    task automatic launch(input logic [31:0] bd);
        @(negedge clk);
        ifc.block_dim = bd;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    task automatic capture(input int n, input int poke, input bit react);
        int wcnt = 0;
        for (int i = 0; i < n; i++) begin
            cap_st[i]   = int'(ifc.simd_state);
            cap_wave[i] = ifc.wave_id;
            cap_pc[i]   = ifc.pc;
            cap_mask[i] = ifc.lane_mask;
            cap_done[i] = ifc.done;
            ifc.start = (i == poke);
            if (i == poke) ifc.block_dim = 32'd5;
            if (react) begin
                if (cap_st[i] == ST_WAIT) begin
                    wcnt++;
                    ifc.mem_ready = (wcnt == 3);
                end else begin
                    wcnt = 0;
                    ifc.mem_ready = (cap_st[i] == ST_EXECUTE);
                end
            end
            @(negedge clk);
        end
        ifc.start = 1'b0;
        ifc.mem_ready = 1'b0;
    endtask

    task automatic wait_state(input string name, input int st, input int budget);
        int n = 0;
        while (int'(ifc.simd_state) != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(ifc.simd_state), 64'(st));
    endtask

    task automatic wait_fetch(input string name, input logic [PC_WIDTH-1:0] exp_pc);
        int n = 0;
        while (int'(ifc.simd_state) == ST_FETCH && n < 100) begin @(negedge clk); n++; end
        while (int'(ifc.simd_state) != ST_FETCH && n < 100) begin @(negedge clk); n++; end
        chk({name, "_reached"}, 64'(int'(ifc.simd_state) == ST_FETCH), 64'd1);
        chk(name, 64'(ifc.pc), 64'(exp_pc));
    endtask

    function automatic logic [31:0] pick_bd();
        case ($urandom % 8)
            0: return 32'd0;
            1: return 32'd20;
            2: return 32'd64;
            3: return 32'($urandom % 200);
            4: return 32'hFFFF_FFFF;
            5: return 32'd33;
            6: return 32'd16;
            default: return 32'd1;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) prog[i] = '0;
        ifc.start = 1'b1; ifc.block_dim = 32'd20; ifc.fetch_valid = 1'b0;
        ifc.branch_taken = 1'b0; ifc.branch_target = '0; ifc.mem_ready = 1'b0;

        // Reset held two cycles with start high
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_state", 64'(ifc.simd_state), 64'd0);
        chk("rst_wave", 64'(ifc.wave_id), 64'd0);
        chk("rst_cycle_pc", 64'({ifc.curr_wave_cycle, ifc.pc}), 64'd0);
        chk("rst_instr", 64'(ifc.instr), 64'd0);
        chk("rst_flags", 64'({ifc.fetch_req, ifc.busy, ifc.done}), 64'd0);
        chk("rst_mask", 64'(ifc.lane_mask), 64'd0);
        ifc.start = 1'b0;
        rst = 1'b0;
        chk_en = 1'b1;

        // Single wave, two instructions
        prog[0] = 32'h0; prog[1] = 32'h2;
        ifc.fetch_valid = 1'b1;
        launch(32'd20);
        capture(18, -1, 1'b0);
        for (int i = 0; i < 18; i++) chk("basic_state", 64'(cap_st[i]), 64'(exp_basic[i]));
        chk("basic_mask_c0", 64'(cap_mask[2]), 64'hFFFF);
        chk("basic_mask_c1", 64'(cap_mask[5]), 64'h000F);
        chk("basic_pc0", 64'(cap_pc[0]), 64'd0);
        chk("basic_pc1", 64'(cap_pc[8]), 64'd1);
        chk("basic_done_early", 64'(cap_done[15]), 64'd0);
        chk("basic_done", 64'(cap_done[16]), 64'd1);

        // Two waves, ret at pc 0, with an ignored start/block_dim change mid-run
        prog[0] = 32'h2;
        launch(32'd64);
        capture(18, 4, 1'b0);
        for (int i = 0; i < 18; i++) chk("multi_state", 64'(cap_st[i]), 64'(exp_basic[i]));
        chk("multi_wave0", 64'(cap_wave[7]), 64'd0);
        chk("multi_wave1", 64'(cap_wave[8]), 64'd1);
        chk("multi_pc_reset", 64'(cap_pc[8]), 64'd0);
        chk("multi_no_early_done", 64'(cap_done[8]), 64'd0);
        chk("multi_done", 64'(cap_done[16]), 64'd1);
        chk("multi_wave_kept", 64'(cap_wave[16]), 64'd1);
        chk("multi_mask_a", 64'(cap_mask[5]), 64'hFFFF);
        chk("multi_mask_b", 64'(cap_mask[13]), 64'hFFFF);

        // Memory stall: three WAIT cycles per lane group, stray mem_ready elsewhere
        prog[0] = 32'h3;
        launch(32'd16);
        capture(16, -1, 1'b1);
        for (int i = 0; i < 16; i++) chk("mem_state", 64'(cap_st[i]), 64'(exp_mem[i]));
        chk("mem_mask_c0", 64'(cap_mask[2]), 64'hFFFF);
        chk("mem_mask_c1", 64'(cap_mask[8]), 64'h0000);

        // Branch to 5, then to 0xFF, then sequential wrap to 0
        prog[0] = 32'h0; prog[5] = 32'h0; prog[255] = 32'h0;
        ifc.branch_taken = 1'b1; ifc.branch_target = 8'h05;
        launch(32'd1);
        wait_fetch("branch_pc5", 8'h05);
        ifc.branch_target = 8'hFF;
        wait_fetch("branch_pcff", 8'hFF);
        ifc.branch_taken = 1'b0;
        prog[0] = 32'h2;
        wait_fetch("wrap_pc0", 8'h00);
        wait_state("branch_done", ST_DONE, 40);
        @(negedge clk);

        // Empty block goes straight to DONE
        launch(32'd0);
        chk("empty_state", 64'(ifc.simd_state), 64'd7);
        chk("empty_done", 64'({ifc.done, ifc.busy}), 64'h3);
        @(negedge clk);
        chk("empty_idle", 64'({ifc.simd_state, ifc.done}), 64'd0);

        // Reset while waiting on memory
        prog[0] = 32'h1;
        ifc.mem_ready = 1'b0;
        launch(32'd40);
        wait_state("wait_reached", ST_WAIT, 20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wait_state", 64'({ifc.simd_state, ifc.busy, ifc.done}), 64'd0);
        chk("rst_wait_pc_wave", 64'({ifc.pc, ifc.wave_id}), 64'd0);
        @(negedge clk);
        chk("rst_wait_no_done", 64'({ifc.simd_state, ifc.done}), 64'd0);

        // Randomized run against the model
        for (int i = 0; i < 256; i++) prog[i] = {$urandom} & 32'hFFFF_FFF0 | 32'($urandom % 2) | (($urandom % 3 == 0) ? 32'h2 : 32'h0);
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            ifc.fetch_valid   = ($urandom % 4) != 0;
            ifc.mem_ready     = ($urandom % 2) != 0;
            ifc.branch_taken  = ($urandom % 3) == 0;
            ifc.branch_target = PC_WIDTH'($urandom % 16);
            ifc.start         = ($urandom % 8) == 0;
            ifc.block_dim     = pick_bd();
            rst               = ($urandom % 700) == 0;
        end
        @(negedge clk);
        ifc.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/simd_sequencer.md
# simd_sequencer

Per-SIMD-unit control sequencer that walks a thread block wave by wave and instruction by instruction. It drives the `simd_state`, `wave_id`, `curr_wave_cycle` and per-cycle lane mask that the 16-lane register files, ALUs and LSU consume. It also owns the PC and the instruction-fetch and memory-wait handshakes.

## Interface
- WAVE_SIZE, 32, threads per wave
- LANE_WIDTH, 16, SIMD lanes; CYCLES = WAVE_SIZE/LANE_WIDTH (integer, ≥1)
- PC_WIDTH, 8, program counter width
- CW = max(1, $clog2(CYCLES)), derived width of curr_wave_cycle
- clk  in  1  clock
- rst  in  1  reset: rst, synchronous, active-high
- start  in  1  launch block; honoured only in IDLE
- block_dim  in  32  threads in block; latched on accepted start
- fetch_req  out  1  high for every FETCH cycle
- fetch_valid  in  1  instruction available at current pc
- instr_in  in  32  fetched instruction
- instr  out  32  latched instruction, to decoder
- is_mem  in  1  decoded: load/store, needs WAIT
- is_ret  in  1  decoded: end of program for this wave
- branch_taken  in  1  uniform branch resolved (valid in UPDATE)
- branch_target  in  PC_WIDTH  branch destination
- mem_ready  in  1  LSU done for current wave cycle
- simd_state  out  3  IDLE=0 FETCH=1 DECODE=2 REQUEST=3 WAIT=4 EXECUTE=5 UPDATE=6 DONE=7
- wave_id  out  32  current wave
- curr_wave_cycle  out  CW  current lane group within wave
- lane_mask  out  LANE_WIDTH  bit l = 1 iff thread wave_id*WAVE_SIZE + curr_wave_cycle*LANE_WIDTH + l < block_dim
- pc  out  PC_WIDTH  current instruction address
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse in DONE

## Operation
- IDLE: on start, latch block_dim; num_waves = ceil(block_dim/WAVE_SIZE), 33-bit intermediate, no overflow. num_waves=0 → DONE; else wave_id=0, pc=0, cycle=0 → FETCH.
- FETCH: fetch_req=1; stay until fetch_valid, then latch instr_in into instr → DECODE.
- DECODE: one cycle; sample is_mem, is_ret into internal flags → REQUEST.
- REQUEST: one cycle (register file reads) → WAIT if mem flag, else EXECUTE.
- WAIT: hold until mem_ready=1 → EXECUTE. mem_ready outside WAIT is ignored.
- EXECUTE: one cycle → UPDATE.
- UPDATE: one cycle (write-back). If cycle < CYCLES-1: cycle+1 → REQUEST; instruction is not refetched. Else cycle=0 and:
  - ret flag set: if wave_id = num_waves-1 → DONE; else wave_id+1, pc=0 → FETCH.
  - otherwise: pc = branch_taken ? branch_target : pc+1 (wraps modulo 2^PC_WIDTH) → FETCH.
- DONE: done=1 for one cycle → IDLE. Outputs wave_id, pc and instr keep their last values.
- lane_mask is combinational from latched block_dim, wave_id and curr_wave_cycle. A fully masked lane group is still sequenced, with mask 0.
- start outside IDLE is ignored. block_dim changes after latch have no effect.

## Timing
- Reset (synchronous, overrides everything): simd_state=IDLE, wave_id=0, curr_wave_cycle=0, pc=0, instr=0, fetch_req=0, busy=0, done=0, internal flags 0; lane_mask reflects latched block_dim=0, i.e. 0.
- All state and outputs are registered except lane_mask, fetch_req, busy and done, which decode the registered state.
- Minimum non-memory instruction, fetch_valid already high: 2 + 3*CYCLES cycles (CYCLES=2 → 8).
- Memory instruction adds k cycles per wave cycle, where k = cycles spent in WAIT (≥1).
- start accepted at edge N → FETCH visible at N+1.
- rst mid-operation → IDLE at the next edge. An in-flight fetch or memory wait is abandoned; no done pulse.

## Test plan
- Reset: assert rst 2 cycles while start=1 → simd_state=0, all outputs 0, no launch until rst drops.
- Single wave, block_dim=20, fetch_valid=1, non-mem instr then ret instr:
  - states 1,2,3,5,6,3,5,6 repeating per instruction.
  - lane_mask = 0xFFFF for cycle 0, 0x000F for cycle 1.
  - pc goes 0→1; done pulses 16 cycles after the FETCH entry.
- Multi-wave, block_dim=64: ret at pc=0 → wave_id 0→1 with pc reset to 0; done only after wave 1; lane_mask 0xFFFF throughout.
- Memory stall: is_mem=1, mem_ready low 3 cycles per WAIT entry → 3 WAIT cycles before each EXECUTE. A mem_ready pulse asserted during EXECUTE is ignored.
- Branch and wrap: branch_taken=1, target=0x05 → pc=5 next FETCH. With PC_WIDTH=8 at pc=0xFF, no branch → pc=0x00.
- Edge cases:
  - block_dim=0 → DONE the cycle after start, done pulse, back to IDLE.
  - start pulsed mid-run → ignored.
  - rst during WAIT → IDLE next cycle, no done.
